// File: rtl/el2_ifu_parcel_aligner_pkg.sv
// el2_ifu_parcel_aligner_pkg: shared parcel type and fetch geometry for the parcel aligner
package el2_ifu_parcel_aligner_pkg;
    localparam int FETCH_PARCELS = 4;
    typedef struct packed {
        logic [15:0] data;
        logic        err;
    } el2_parcel_t;
    // A faulted parcel is always emitted alone, so it counts as a one-parcel instruction
    function automatic logic parcel_is16(el2_parcel_t p);
        return p.err || (p.data[1:0] != 2'b11);
    endfunction
endpackage

// File: rtl/el2_ifu_parcel_buf.sv
// el2_ifu_parcel_buf: circular parcel buffer, 4-wide variable-count write, 2-wide read at head
module el2_ifu_parcel_buf
    import el2_ifu_parcel_aligner_pkg::*;
#(
    parameter int BUF_PARCELS = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               enq,
    input  logic [1:0]                         enq_start,
    input  logic [16*FETCH_PARCELS-1:0]        enq_data,
    input  logic                               enq_err,
    input  logic                               deq,
    input  logic                               deq_two,
    output logic [$clog2(BUF_PARCELS):0]       count,
    output el2_parcel_t                        rd0,
    output el2_parcel_t                        rd1
);
    localparam int PW = $clog2(BUF_PARCELS);
    localparam int CW = PW + 1;
    el2_parcel_t     mem [BUF_PARCELS];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW-1:0]   head1;
    logic [2:0]      enq_n;
    logic [1:0]      deq_n;
    assign enq_n = enq ? 3'd4 - {1'b0, enq_start} : 3'd0;
    assign deq_n = deq ? (deq_two ? 2'd2 : 2'd1) : 2'd0;
    assign head1 = head + PW'(1);
    assign rd0   = mem[head];
    assign rd1   = mem[head1];
    // Write the valid tail of the packet, advance pointers and keep the occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < BUF_PARCELS; i++) mem[i] <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < FETCH_PARCELS; i++)
                if (enq && (2'(i) >= enq_start))
                    mem[tail + PW'(i) - PW'(enq_start)] <= {enq_data[16*i +: 16], enq_err};
            tail  <= tail + PW'(enq_n);
            head  <= head + PW'(deq_n);
            count <= count + CW'(enq_n) - CW'(deq_n);
        end
    end
endmodule

// File: rtl/el2_ifu_parcel_aligner.sv
// el2_ifu_parcel_aligner: turns fetch packets into one aligned instruction per cycle with PC and length
module el2_ifu_parcel_aligner
    import el2_ifu_parcel_aligner_pkg::*;
#(
    parameter int BUF_PARCELS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [63:0] fetch_data,
    input  logic [30:0] fetch_pc,
    input  logic [1:0]  fetch_start,
    input  logic        fetch_err,
    output logic        aln_valid,
    input  logic        aln_ready,
    output logic [31:0] aln_inst,
    output logic [15:0] aln_cinst,
    output logic        aln_is16,
    output logic [30:0] aln_pc,
    output logic        aln_err
);
    localparam int CW = $clog2(BUF_PARCELS) + 1;
    logic [CW-1:0] count;
    el2_parcel_t   h0;
    el2_parcel_t   h1;
    logic          is16;
    logic          enq;
    logic          deq;
    logic [1:0]    deq_n;
    logic [30:0]   head_pc;
    el2_ifu_parcel_buf #(.BUF_PARCELS(BUF_PARCELS)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .enq       (enq),
        .enq_start (fetch_start),
        .enq_data  (fetch_data),
        .enq_err   (fetch_err),
        .deq       (deq),
        .deq_two   (!is16),
        .count     (count),
        .rd0       (h0),
        .rd1       (h1)
    );
    assign is16        = parcel_is16(h0);
    assign fetch_ready = !flush && (count <= CW'(BUF_PARCELS - FETCH_PARCELS));
    assign enq         = fetch_valid && fetch_ready;
    assign aln_valid   = !flush && (((count >= CW'(1)) && is16) || (count >= CW'(2)));
    assign deq         = aln_valid && aln_ready;
    assign deq_n       = deq ? (is16 ? 2'd1 : 2'd2) : 2'd0;
    assign aln_inst    = is16 ? {16'h0000, h0.data} : {h1.data, h0.data};
    assign aln_cinst   = h0.data;
    assign aln_is16    = is16;
    assign aln_err     = h0.err || (!is16 && h1.err);
    assign aln_pc      = head_pc;
    // Head PC reloads from the fetch PC when the buffer drains to empty, else steps by consumed parcels
    always_ff @(posedge clk) begin
        if (rst)
            head_pc <= '0;
        else if (enq && (count == CW'(deq_n)))
            head_pc <= fetch_pc + 31'(fetch_start);
        else if (deq)
            head_pc <= head_pc + 31'(deq_n);
    end
endmodule

// File: doc/el2_ifu_parcel_aligner.md
Name: el2_ifu_parcel_aligner

Overview:
- Sits between the fetch data return and the 16→32 compressed-instruction expander.
- Buffers 16-bit parcels from 64-bit fetch packets, finds instruction boundaries, and presents one instruction per cycle with its PC and length.
- For compressed instructions, drives the raw 16-bit parcel on aln_cinst for the downstream expander to consume.
- Handles instructions that straddle packets, unaligned fetch starts, backpressure and flush.

Parameters:
- FETCH_PARCELS, 4: 16-bit parcels per fetch packet (fixed at 4; fetch_data is 64 bits).
- BUF_PARCELS, 8: parcel buffer depth; power of two, >= 2*FETCH_PARCELS.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard all buffered parcels (redirect)
- fetch_valid  input  1  fetch packet valid
- fetch_ready  output  1  packet accepted when valid&ready
- fetch_data  input  64  parcels p0=[15:0] .. p3=[63:48]
- fetch_pc  input  31  PC[31:1] of parcel 0
- fetch_start  input  2  index of first valid parcel (branch target offset)
- fetch_err  input  1  access fault for whole packet
- aln_valid  output  1  instruction at head is complete
- aln_ready  input  1  consumer takes instruction when valid&ready
- aln_inst  output  32  raw instruction; upper 16 zero when aln_is16
- aln_cinst  output  16  head parcel, to the expander
- aln_is16  output  1  instruction is one parcel
- aln_pc  output  31  PC[31:1] of instruction
- aln_err  output  1  fault on any parcel of instruction

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Names are clk and rst.
- Reset: count=0, head/tail ptr=0, head_pc=0.
  - All outputs 0 except those derived combinationally from empty state: aln_valid=0, fetch_ready=1 from the cycle after reset deasserts.
- Storage: circular buffer of BUF_PARCELS entries, each holding {parcel[15:0], err}.
  - count width is clog2(BUF_PARCELS)+1.
- Accept rule: fetch_ready = !flush & (count <= BUF_PARCELS-FETCH_PARCELS).
  - The free-space check uses count before this cycle's dequeue; no bypass from dequeue to ready.
- Enqueue: parcels fetch_start..3 are written in order at the tail; tail advances by 4-fetch_start; all written entries take err=fetch_err.
- Length decode at head:
  - head parcel [1:0]!=2'b11 → 16-bit.
  - Otherwise → 32-bit, needing count>=2.
- aln_valid = !flush & ((count>=1 & is16) | (count>=2) | (count>=1 & head err)).
- A head parcel with err set is always emitted alone: is16=1, aln_err=1, consumes 1 parcel.
- For a 32-bit instruction, aln_err = err of head or of head+1.
- Output path is combinational from the buffer head. Latency from packet accept to aln_valid is 1 cycle; no bypass from fetch to aln.
- Dequeue on aln_valid&aln_ready: head ptr and count decrement by 1 or 2.
- Simultaneous enqueue and dequeue: count += enq_n - deq_n. Never overflows by the accept rule.
- head_pc update:
  - Load fetch_pc+fetch_start on enqueue when count-deq_n==0.
  - Else on dequeue, add deq_n.
  - Else hold.
  - All arithmetic is modulo 2^31.
- Sequencing contract: upstream delivers sequential packets between flushes. The block does not check PC continuity.
- Straddle: a 32-bit head with count==1 holds aln_valid=0 until the next packet lands. The upper half is taken from the wrapped buffer entry.
- Pointer wrap: pointers are modulo BUF_PARCELS. Indexing head+1 wraps.
- Flush:
  - In the flush cycle, aln_valid=0, fetch_ready=0, and no enqueue or dequeue occurs.
  - Next cycle: count=0, ptrs=0.
  - Flush wins over everything, including reset-free simultaneous events. rst dominates flush.
- Stable outputs: while aln_valid=1 and aln_ready=0, all aln_* outputs are stable. A subsequent enqueue cannot change the head.

Decomposition:
- el2_pkg: localparam FETCH_PARCELS, and typedef el2_parcel_t {logic [15:0] data; logic err;}.
- One sub-module: el2_ifu_parcel_buf.
  - Circular buffer with 4-wide variable-count write and 2-wide read port (head, head+1).
  - Exposes count.
- The top holds length decode, head_pc and handshakes.

Test Plan:
1. Reset, then packet fetch_pc=0x100>>1, start=0, data=0x0000_0013_4501_4505, aln_ready=1 → 3 consecutive outputs:
   - 0x4505 is16 pc 0x100
   - 0x4501 is16 pc 0x102
   - 0x00000013 is16=0 pc 0x104
   - count returns to 0.
2. Straddle: packet A (pc 0x200) with p3=0x0513, other parcels 16-bit; next packet B p0=0x0010 is delayed 3 cycles → aln_valid=0 while 0x0513 waits, then 0x00100513 pc 0x206 is16=0.
3. Unaligned start: pc 0x300, start=2, data p2=0x4505, p3=0x4501 → first output pc 0x304, only 2 instructions, no output from p0/p1.
4. Backpressure: aln_ready=0, offer 3 all-16-bit packets → first 2 accepted (count=8), fetch_ready=0, third held and outputs stable. Release aln_ready=1 → third accepted once count<=4, 12 instructions in order.
5. Flush mid-straddle: half instruction buffered, assert flush 1 cycle, then packet at 0x400 → first output pc 0x400; stale parcel never emitted.
6. Fault: packet with fetch_err=1, head p0=0x0513 → output is16=1, aln_err=1, pc=fetch pc; next parcel emitted next cycle with aln_err=1.
